// File: rtl/pinf_skew_pkg.sv
// rtl/pinf_skew_pkg.sv - shared state encoding and default constants for the pinf skew trainer
package pinf_skew_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_RECORD,
    ST_CENTER
  } skew_state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_TAPS   = 16;
  localparam int DEF_TAP_W      = 4;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_CHECK_CYC  = 64;
  localparam int DEF_MIN_WIN    = 3;

endpackage

// File: rtl/pinf_window_tracker.sv
// rtl/pinf_window_tracker.sv - tracks the current passing run and the widest run seen in a sweep
module pinf_window_tracker
  import pinf_skew_pkg::*;
#(
  parameter int TAP_W = DEF_TAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             record,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  localparam logic [TAP_W:0] LEN_ONE = (TAP_W+1)'(1);

  logic [TAP_W-1:0] run_start;
  logic [TAP_W:0]   run_len;
  logic [TAP_W-1:0] run_start_nx;
  logic [TAP_W:0]   run_len_nx;

  always_comb begin
    run_start_nx = run_start;
    run_len_nx   = run_len;
    if (pass) begin
      if (run_len == '0) run_start_nx = tap;
      run_len_nx = run_len + LEN_ONE;
    end else begin
      run_len_nx = '0;
    end
  end

  // Strict greater-than keeps the earliest run when two runs tie.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (record) begin
      run_start <= run_start_nx;
      run_len   <= run_len_nx;
      if (run_len_nx > best_len) begin
        best_start <= run_start_nx;
        best_len   <= run_len_nx;
      end
    end
  end

endmodule

// File: rtl/pinf_skew_trainer.sv
// rtl/pinf_skew_trainer.sv - tap sweep sequencer that centres the pinf capture delay; SKEW_TRAIN_ERRCNT_EN adds err_cnt/bad_map
module pinf_skew_trainer
  import pinf_skew_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int TAP_W      = DEF_TAP_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CHECK_CYC  = DEF_CHECK_CYC,
  parameter int MIN_WIN    = DEF_MIN_WIN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cap_data,
  input  logic [DATA_W-1:0] pattern,
  output logic [TAP_W-1:0]  tap_sel,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              fail,
  output logic [TAP_W-1:0]  win_lo,
  output logic [TAP_W-1:0]  win_hi
`ifdef SKEW_TRAIN_ERRCNT_EN
  ,
  output logic [15:0]         err_cnt,
  output logic [NUM_TAPS-1:0] bad_map
`endif
);

  localparam int CNT_MAX = (CHECK_CYC > SETTLE_CYC) ? CHECK_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYC - 1);
  localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
  localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W:0]   MIN_LEN     = (TAP_W+1)'(MIN_WIN);

  skew_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             tap_bad, tap_bad_nx;
  logic [TAP_W-1:0] tap_sel_nx, win_lo_nx, win_hi_nx;
  logic             busy_nx, done_nx, locked_nx, fail_nx;

  logic             trk_clear, trk_record;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W:0]   best_len;
  logic [TAP_W-1:0] len_m1;
  logic             mismatch;

  assign mismatch = (cap_data != pattern);
  // best_len never exceeds NUM_TAPS, so the low bits minus one give len-1 even at full width.
  assign len_m1   = best_len[TAP_W-1:0] - TAP_ONE;

  pinf_window_tracker #(
    .TAP_W (TAP_W)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (trk_clear),
    .record     (trk_record),
    .pass       (!tap_bad),
    .tap        (tap_sel),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tap_bad <= 1'b0;
      tap_sel <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      locked  <= 1'b0;
      fail    <= 1'b0;
      win_lo  <= '0;
      win_hi  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tap_bad <= tap_bad_nx;
      tap_sel <= tap_sel_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      locked  <= locked_nx;
      fail    <= fail_nx;
      win_lo  <= win_lo_nx;
      win_hi  <= win_hi_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    tap_bad_nx = tap_bad;
    tap_sel_nx = tap_sel;
    busy_nx    = busy;
    done_nx    = 1'b0;
    locked_nx  = locked;
    fail_nx    = fail;
    win_lo_nx  = win_lo;
    win_hi_nx  = win_hi;
    trk_clear  = 1'b0;
    trk_record = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx   = ST_SETTLE;
          cnt_nx     = '0;
          tap_sel_nx = '0;
          locked_nx  = 1'b0;
          fail_nx    = 1'b0;
          busy_nx    = 1'b1;
          trk_clear  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nx   = ST_CHECK;
          cnt_nx     = '0;
          tap_bad_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (mismatch) tap_bad_nx = 1'b1;
        if (cnt == CHECK_LAST) begin
          state_nx = ST_RECORD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_RECORD: begin
        trk_record = 1'b1;
        if (tap_sel == TAP_LAST) begin
          state_nx = ST_CENTER;
        end else begin
          tap_sel_nx = tap_sel + TAP_ONE;
          state_nx   = ST_SETTLE;
        end
      end
      ST_CENTER: begin
        state_nx = ST_IDLE;
        busy_nx  = 1'b0;
        if (best_len >= MIN_LEN) begin
          tap_sel_nx = best_start + (len_m1 >> 1);
          win_lo_nx  = best_start;
          win_hi_nx  = best_start + len_m1;
          locked_nx  = 1'b1;
          done_nx    = 1'b1;
        end else begin
          tap_sel_nx = '0;
          win_lo_nx  = '0;
          win_hi_nx  = '0;
          fail_nx    = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef SKEW_TRAIN_ERRCNT_EN
  logic [15:0]         err_cnt_nx;
  logic [NUM_TAPS-1:0] bad_map_nx;

  always_comb begin
    err_cnt_nx = err_cnt;
    bad_map_nx = bad_map;
    case (state)
      ST_IDLE: begin
        if (start) begin
          err_cnt_nx = '0;
          bad_map_nx = '0;
        end
      end
      ST_CHECK: begin
        if (mismatch && err_cnt != 16'hFFFF) err_cnt_nx = err_cnt + 16'd1;
      end
      ST_RECORD: bad_map_nx[tap_sel] = tap_bad;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
      bad_map <= '0;
    end else begin
      err_cnt <= err_cnt_nx;
      bad_map <= bad_map_nx;
    end
  end
`endif

endmodule

// File: tb/tb_pinf_skew_trainer.sv
// tb/tb_pinf_skew_trainer.sv - scoreboard bench for the pinf skew trainer; SKEW_TRAIN_ERRCNT_EN enables err_cnt/bad_map checks
module tb_pinf_skew_trainer;

  localparam int SWEEP_CYC = 1170;
  localparam int TIMEOUT   = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cap_data = '0;
  logic [31:0] pattern = '0;
  logic [3:0]  tap_sel;
  logic        busy, done, locked, fail;
  logic [3:0]  win_lo, win_hi;
`ifdef SKEW_TRAIN_ERRCNT_EN
  logic [15:0] err_cnt;
  logic [15:0] bad_map;
`endif

  typedef struct {
    logic       locked;
    logic       fail;
    logic       done;
    logic [3:0] tap;
    logic [3:0] lo;
    logic [3:0] hi;
    int         cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] pass_mask = '0;
  logic [31:0] flip = 32'h1;
  bit          inject = 1'b0;

  pinf_skew_trainer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cap_data (cap_data),
    .pattern  (pattern),
    .tap_sel  (tap_sel),
    .busy     (busy),
    .done     (done),
    .locked   (locked),
    .fail     (fail),
    .win_lo   (win_lo),
    .win_hi   (win_hi)
`ifdef SKEW_TRAIN_ERRCNT_EN
    ,
    .err_cnt  (err_cnt),
    .bad_map  (bad_map)
`endif
  );

  always #5 clk = ~clk;

  // Emulates the tap mux: a masked-off tap returns a one-bit-corrupted word.
  task automatic drive_cap();
    bit good;
    good = pass_mask[tap_sel] && !(inject && tap_sel < 4'd4 && (cyc % 8) == 0);
    cap_data = good ? pattern : (pattern ^ flip);
  endtask

  task automatic new_pattern();
    pattern = $urandom;
    flip    = 32'h1 << $urandom_range(31, 0);
  endtask

  task automatic push_exp(input logic lk, input logic fl, input logic [3:0] tap,
                          input logic [3:0] lo, input logic [3:0] hi);
    exp_t e;
    e.locked = lk;
    e.fail   = fl;
    e.done   = lk;
    e.tap    = tap;
    e.lo     = lo;
    e.hi     = hi;
    e.cycles = SWEEP_CYC;
    sb.push_back(e);
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({tap_sel, busy, done, locked, fail, win_lo, win_hi} !== 15'd0) begin
      errors++;
      $display("FAIL %s outputs: tap_sel=%0d busy=%0b done=%0b locked=%0b fail=%0b win_lo=%0d win_hi=%0d want all 0",
               name, tap_sel, busy, done, locked, fail, win_lo, win_hi);
    end
`ifdef SKEW_TRAIN_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd0 || bad_map !== 16'd0) begin
      errors++;
      $display("FAIL %s errcnt: err_cnt=%0d bad_map=%h want 0/0000", name, err_cnt, bad_map);
    end
`endif
  endtask

  // Runs one sweep; optionally pokes start mid-sweep or during CENTER, or resets at a given tap.
  task automatic run_sweep(input string name, input logic [15:0] mask, input bit inj,
                           input bit center_start, input int mid_start, input int rst_tap);
    exp_t e;
    int   cycles;
    pass_mask = mask;
    inject    = inj;
    @(negedge clk);
    drive_cap();
    start = 1'b1;
    @(posedge clk);
    #1;
    cycles = 1;
    cyc++;
    start = 1'b0;
    drive_cap();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_on_accept: got %0b want 1", name, busy);
    end
    while (!(done || fail) && cycles < TIMEOUT) begin
      start = (center_start && cycles == SWEEP_CYC - 1) || (cycles == mid_start);
      @(posedge clk);
      #1;
      cycles++;
      cyc++;
      drive_cap();
      if (rst_tap >= 0 && int'(tap_sel) == rst_tap) begin
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle_zero({name, "_abort"});
        return;
      end
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (cycles !== e.cycles) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cycles, e.cycles);
    end
    checks++;
    if (done !== e.done || locked !== e.locked || fail !== e.fail) begin
      errors++;
      $display("FAIL %s status: done=%0b locked=%0b fail=%0b want %0b/%0b/%0b",
               name, done, locked, fail, e.done, e.locked, e.fail);
    end
    checks++;
    if (tap_sel !== e.tap || win_lo !== e.lo || win_hi !== e.hi) begin
      errors++;
      $display("FAIL %s window: tap_sel=%0d win_lo=%0d win_hi=%0d want %0d/%0d/%0d",
               name, tap_sel, win_lo, win_hi, e.tap, e.lo, e.hi);
    end
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || locked !== e.locked || fail !== e.fail) begin
      errors++;
      $display("FAIL %s after_end: busy=%0b done=%0b locked=%0b fail=%0b want 0/0/%0b/%0b",
               name, busy, done, locked, fail, e.locked, e.fail);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle_zero("reset");
  endtask

  task automatic test_window_5_10();
    new_pattern();
    push_exp(1'b1, 1'b0, 4'd7, 4'd5, 4'd10);
    run_sweep("win_5_10", 16'h07E0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_tie_earliest();
    new_pattern();
    push_exp(1'b1, 1'b0, 4'd2, 4'd1, 4'd3);
    run_sweep("tie", 16'h0E0E, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_short_window();
    new_pattern();
    push_exp(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
    run_sweep("short", 16'h0030, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_no_pass();
    new_pattern();
    push_exp(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
    run_sweep("none", 16'h0000, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_all_pass();
    new_pattern();
    push_exp(1'b1, 1'b0, 4'd7, 4'd0, 4'd15);
    run_sweep("all_pass", 16'hFFFF, 1'b0, 1'b1, -1, -1);
`ifdef SKEW_TRAIN_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd0 || bad_map !== 16'h0000) begin
      errors++;
      $display("FAIL all_pass errcnt: err_cnt=%0d bad_map=%h want 0/0000", err_cnt, bad_map);
    end
`endif
  endtask

  task automatic test_abort_restart();
    new_pattern();
    run_sweep("abort", 16'h07E0, 1'b0, 1'b0, 300, 6);
    push_exp(1'b1, 1'b0, 4'd7, 4'd5, 4'd10);
    run_sweep("restart", 16'h07E0, 1'b0, 1'b0, 300, -1);
  endtask

  task automatic test_errcnt_inject();
    new_pattern();
    push_exp(1'b1, 1'b0, 4'd9, 4'd4, 4'd15);
    run_sweep("inject", 16'hFFFF, 1'b1, 1'b0, -1, -1);
`ifdef SKEW_TRAIN_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd32 || bad_map !== 16'h000F) begin
      errors++;
      $display("FAIL inject errcnt: err_cnt=%0d bad_map=%h want 32/000f", err_cnt, bad_map);
    end
`endif
    inject = 1'b0;
  endtask

  initial begin
    test_reset();
    test_window_5_10();
    test_tie_earliest();
    test_short_window();
    test_all_pass();
    test_no_pass();
    test_abort_restart();
    test_errcnt_inject();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pinf_skew_trainer.md
Name: pinf_skew_trainer

Overview:
- Sequencer for a tapped delay chain built from DELAY_BUF arrays on the parallel-interface (pinf) capture path.
- Sweeps the tap select across all taps and checks a static training pattern at each tap.
- Finds the widest contiguous run of passing taps and locks the tap select to the centre of that run.
- Sits between the pinf tap mux / capture register and the video pipeline; training runs once after power-up or on demand.

Parameters:
- DATA_W, 32, width of the captured word compared against the pattern.
- NUM_TAPS, 16, number of delay taps; tap_sel ranges 0..NUM_TAPS-1.
- TAP_W, 4, width of tap_sel; must equal $clog2(NUM_TAPS).
- SETTLE_CYC, 8, cycles to wait after changing tap_sel before sampling starts.
- CHECK_CYC, 64, number of consecutive samples compared per tap.
- MIN_WIN, 3, minimum passing-run length needed to declare lock.

Ports:
- clk, input, 1, single clock; the capture register is also clocked by this clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, pulse that begins a sweep; ignored while busy.
- cap_data, input, DATA_W, registered data from the tap mux.
- pattern, input, DATA_W, expected training word; quasi-static during a sweep.
- tap_sel, output, TAP_W, drives the tap mux select.
- busy, output, 1, high from the cycle after start is accepted until done or fail.
- done, output, 1, one-cycle pulse when lock is achieved.
- locked, output, 1, level; high after a successful sweep, cleared on the next start.
- fail, output, 1, level; high after an unsuccessful sweep, cleared on the next start.
- win_lo, output, TAP_W, first tap of the best run.
- win_hi, output, TAP_W, last tap of the best run.

Behaviour:
- Reset (rst_n=0 at clk edge): every output is 0 (tap_sel=0, busy=0, done=0, locked=0, fail=0, win_lo=0, win_hi=0); state goes to IDLE.
- States: IDLE -> SETTLE -> CHECK -> RECORD -> (SETTLE | CENTER) -> IDLE.
- IDLE: on start=1, go to SETTLE. In the same transition: clear locked/fail, set tap_sel=0, clear run/best trackers, set busy=1.
- SETTLE: count SETTLE_CYC cycles, then go to CHECK.
- CHECK: compare cap_data==pattern for CHECK_CYC cycles. Any mismatch latches tap_bad=1. After the last sample go to RECORD.
- RECORD (one cycle):
  - Pass: if run_len==0, run_start=tap_sel; run_len++.
  - Bad: run_len=0.
  - After this update, if run_len>best_len, copy the run into best (strict >, so on a tie the earliest run wins).
  - If tap_sel==NUM_TAPS-1, go to CENTER; else tap_sel++ and go to SETTLE.
- CENTER (one cycle):
  - If best_len>=MIN_WIN: tap_sel = best_start + (best_len-1)/2 (floor), win_lo=best_start, win_hi=best_start+best_len-1, locked=1, done pulses 1 for this cycle.
  - Else: tap_sel=0, win_lo=win_hi=0, fail=1.
  - In both cases busy=0 next cycle and the state returns to IDLE.
- Boundaries:
  - A run that is still open at the last tap is evaluated in RECORD of that tap; no wrap-around between tap NUM_TAPS-1 and tap 0.
  - All taps pass: best run is 0..NUM_TAPS-1 and tap_sel = (NUM_TAPS-1)/2.
  - No taps pass: fail.
  - start while busy is ignored; start in the same cycle as CENTER is ignored.
  - rst_n low mid-sweep aborts immediately to reset values.
- Latency per full sweep: 1 + NUM_TAPS*(SETTLE_CYC+CHECK_CYC+1) + 1 cycles, from the start-accept edge to the done/fail edge. With defaults this is 1170.
- Arithmetic: run_len and best_len are TAP_W+1 bits wide; the counters never overflow by construction.

Optional Feature:
- Macro: SKEW_TRAIN_ERRCNT_EN.
- When defined:
  - Adds output err_cnt, 16 bits: total mismatching samples across the last sweep, saturating at 16'hFFFF.
  - Adds output bad_map, NUM_TAPS bits: bit i set when tap i failed.
  - Both are cleared when start is accepted, update in CHECK/RECORD, and are 0 at reset.
- When undefined: neither port nor its logic exists; the rest of the behaviour is identical.

Decomposition:
- Shared package pinf_skew_pkg holds:
  - the state enum (ST_IDLE, ST_SETTLE, ST_CHECK, ST_RECORD, ST_CENTER);
  - the default constants for NUM_TAPS, SETTLE_CYC, CHECK_CYC and MIN_WIN.
- One sub-module, pinf_window_tracker:
  - Inputs: tap index, pass/bad flag, record strobe, clear.
  - Outputs: best_start, best_len.
  - Holds the run/best registers and the tie rule.
- The FSM, counters and centre computation stay in pinf_skew_trainer.

Test Plan:
- Taps 5..10 pass, others mismatch; pulse start -> done after 1170 cycles; tap_sel=7, win_lo=5, win_hi=10, locked=1.
- Two runs, taps 1..3 and 9..11 (equal length) -> earliest run wins; tap_sel=2, win_lo=1, win_hi=3.
- Only taps 4..5 pass (length 2 < MIN_WIN) -> fail=1, locked=0, tap_sel=0; done never pulses.
- All 16 taps pass -> tap_sel=7, win_lo=0, win_hi=15. With SKEW_TRAIN_ERRCNT_EN: err_cnt=0, bad_map=16'h0000.
- Re-pulse start mid-sweep (ignored), then drive rst_n=0 for 1 cycle at tap 6 -> all outputs 0 next cycle, state IDLE; a new start gives a clean sweep.
- With SKEW_TRAIN_ERRCNT_EN, one mismatch injected every 8 samples on taps 0..3 only -> err_cnt=32, bad_map=16'h000F.
